// File: rtl/lab4_branch_pht_pkg.sv
// Shared types, counter encodings and the saturating
// counter update for the PHT access scheduler.
package lab4_branch_pht_pkg;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    UPD_WR
  } state_t;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] sat_update(
    input logic [1:0] ctr,
    input logic       taken
  );
    logic [1:0] res;
    res = ctr;
    if (taken) begin
      if (ctr != ST) res = ctr + 2'd1;
    end else begin
      if (ctr != SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/lab4_branch_pht_upd_fifo.sv
// Update queue of {idx, taken} entries with an associative
// lookup so pending updates can hold off same-index lookups.
module lab4_branch_pht_upd_fifo
  import lab4_branch_pht_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [IDX_W-1:0] push_idx,
  input  logic             push_taken,
  input  logic             pop,
  output logic [IDX_W-1:0] head_idx,
  output logic             head_taken,
  output logic             full,
  output logic             empty,
  input  logic [IDX_W-1:0] query_idx,
  output logic             query_hit
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_entry_t;

  upd_entry_t        slots [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              do_push;
  logic              do_pop;
  logic [PW-1:0]     occ;

  assign full       = (count == (PW+1)'(DEPTH));
  assign empty      = (count == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_idx   = slots[rd_ptr].idx;
  assign head_taken = slots[rd_ptr].taken;

  // Pointers and occupancy; power-of-two depth wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy masks stale slots.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= '{idx: push_idx, taken: push_taken};
  end

  // Any occupied slot matching the lookup index.
  always_comb begin
    query_hit = 1'b0;
    occ       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = PW'(i) - rd_ptr;
      if ({1'b0, occ} < count && slots[i].idx == query_idx)
        query_hit = 1'b1;
    end
  end

endmodule

// File: rtl/lab4_branch_pht_sched.sv
// PHT port scheduler: post-reset counter sweep, then arbitration
// between prediction reads and queued read-modify-write updates.
module lab4_branch_pht_sched
  import lab4_branch_pht_pkg::*;
#(
  parameter  int PHT_size    = 2048,
  parameter  int UPD_Q_DEPTH = 4,
  localparam int IDX_W       = $clog2(PHT_size)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_val,
  output logic             pred_rdy,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_resp_val,
  output logic             pred_taken,
  input  logic             upd_val,
  output logic             upd_rdy,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             pht_en,
  output logic             pht_wen,
  output logic [IDX_W-1:0] pht_addr,
  output logic [1:0]       pht_wdata,
  input  logic [1:0]       pht_rdata
);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] sweep_cnt;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_taken;
  logic             resp_q;

  logic             q_full;
  logic             q_empty;
  logic             q_push;
  logic             q_pop;
  logic             q_hit;
  logic [IDX_W-1:0] head_idx;
  logic             head_taken;

  logic             upd_forced;
  logic             take_upd;
  logic             take_pred;

  logic             en_c;
  logic             wen_c;
  logic             rdy_c;
  logic [IDX_W-1:0] addr_c;
  logic [1:0]       wdata_c;

  // A pending update to the looked-up index must land first.
  assign upd_forced = q_full || (pred_val && q_hit);
  assign take_upd   = upd_forced || (!pred_val && !q_empty);
  assign take_pred  = pred_val && !upd_forced;

  assign upd_rdy = !reset && !q_full && (state != INIT);
  assign q_push  = upd_val && upd_rdy;

  lab4_branch_pht_upd_fifo #(
    .DEPTH (UPD_Q_DEPTH),
    .IDX_W (IDX_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (q_push),
    .push_idx   (upd_idx),
    .push_taken (upd_taken),
    .pop        (q_pop),
    .head_idx   (head_idx),
    .head_taken (head_taken),
    .full       (q_full),
    .empty      (q_empty),
    .query_idx  (pred_idx),
    .query_hit  (q_hit)
  );

  // Next state and PHT port drive for the current state.
  always_comb begin
    state_nx = state;
    en_c     = 1'b0;
    wen_c    = 1'b0;
    rdy_c    = 1'b0;
    addr_c   = '0;
    wdata_c  = SNT;
    q_pop    = 1'b0;
    unique case (state)
      INIT: begin
        en_c    = 1'b1;
        wen_c   = 1'b1;
        addr_c  = sweep_cnt;
        wdata_c = WNT;
        if (sweep_cnt == IDX_W'(PHT_size - 1))
          state_nx = IDLE;
      end
      IDLE: begin
        unique case (1'b1)
          take_upd: begin
            q_pop    = !reset;
            en_c     = 1'b1;
            addr_c   = head_idx;
            state_nx = UPD_WR;
          end
          take_pred: begin
            rdy_c  = 1'b1;
            en_c   = 1'b1;
            addr_c = pred_idx;
          end
          default: ;
        endcase
      end
      UPD_WR: begin
        en_c     = 1'b1;
        wen_c    = 1'b1;
        addr_c   = wr_idx;
        wdata_c  = sat_update(pht_rdata, wr_taken);
        state_nx = IDLE;
      end
      default: state_nx = INIT;
    endcase
  end

  // Outputs are forced quiet while reset is held.
  assign pht_en        = en_c && !reset;
  assign pht_wen       = wen_c && !reset;
  assign pht_addr      = reset ? '0 : addr_c;
  assign pht_wdata     = reset ? SNT : wdata_c;
  assign pred_rdy      = rdy_c && !reset;
  assign pred_resp_val = resp_q && !reset;
  assign pred_taken    = pred_resp_val && pht_rdata[1];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= state_nx;
  end

  // Initialization sweep address.
  always_ff @(posedge clk) begin
    if (reset)              sweep_cnt <= '0;
    else if (state == INIT) sweep_cnt <= sweep_cnt + IDX_W'(1);
  end

  // Lookup response is valid the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (reset) resp_q <= 1'b0;
    else       resp_q <= pred_val && pred_rdy;
  end

  // Latch the popped head for the write-back cycle.
  always_ff @(posedge clk) begin
    if (q_pop) begin
      wr_idx   <= head_idx;
      wr_taken <= head_taken;
    end
  end

endmodule

// File: tb/tb_lab4_branch_pht_sched.sv
// Directed bench for the PHT scheduler with a cycle-level
// reference model of port usage, ordering and counter values.
module tb_lab4_branch_pht_sched;

  localparam int N  = 8;
  localparam int D  = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pred_val = 1'b0;
  logic [IW-1:0] pred_idx = '0;
  logic          upd_val = 1'b0;
  logic [IW-1:0] upd_idx = '0;
  logic          upd_taken = 1'b0;
  logic [1:0]    pht_rdata = '0;
  logic          pred_rdy;
  logic          pred_resp_val;
  logic          pred_taken;
  logic          upd_rdy;
  logic          pht_en;
  logic          pht_wen;
  logic [IW-1:0] pht_addr;
  logic [1:0]    pht_wdata;

  logic          pl_en = 1'b0;
  logic [IW-1:0] pl_idx = '0;
  logic [1:0]    pl_val = '0;
  logic [1:0]    mem [N];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lab4_branch_pht_sched #(
    .PHT_size    (N),
    .UPD_Q_DEPTH (D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pred_val      (pred_val),
    .pred_rdy      (pred_rdy),
    .pred_idx      (pred_idx),
    .pred_resp_val (pred_resp_val),
    .pred_taken    (pred_taken),
    .upd_val       (upd_val),
    .upd_rdy       (upd_rdy),
    .upd_idx       (upd_idx),
    .upd_taken     (upd_taken),
    .pht_en        (pht_en),
    .pht_wen       (pht_wen),
    .pht_addr      (pht_addr),
    .pht_wdata     (pht_wdata),
    .pht_rdata     (pht_rdata)
  );

  // PHT SRAM with a side preload port for directed setup.
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (pht_en) begin
      if (pht_wen) mem[pht_addr] <= pht_wdata;
      else         pht_rdata <= mem[pht_addr];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int t);
    if (t != 0) return (v >= 3) ? 3 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  int gold [N];
  int qi [$];
  int qt [$];
  bit busy;
  int p_idx;
  int p_tk;
  bit resp_pend;
  int resp_exp;
  int init_k;

  // Reference model: checks every port every cycle, then
  // advances to what the coming clock edge should produce.
  always @(negedge clk) begin
    if (reset) begin
      chk("rst_en", int'(pht_en), 0);
      chk("rst_wen", int'(pht_wen), 0);
      chk("rst_addr", int'(pht_addr), 0);
      chk("rst_wdata", int'(pht_wdata), 0);
      chk("rst_prdy", int'(pred_rdy), 0);
      chk("rst_urdy", int'(upd_rdy), 0);
      chk("rst_rval", int'(pred_resp_val), 0);
      chk("rst_taken", int'(pred_taken), 0);
      qi.delete();
      qt.delete();
      busy      = 0;
      resp_pend = 0;
      init_k    = 0;
      foreach (gold[i]) gold[i] = 1;
    end else begin
      bit exp_urdy;
      bit acc;
      bit hit;
      int nq;
      chk("resp_val", int'(pred_resp_val), int'(resp_pend));
      if (resp_pend) chk("pred_taken", int'(pred_taken), resp_exp);
      resp_pend = 0;
      if (init_k < N) begin
        chk("init_en", int'(pht_en), 1);
        chk("init_wen", int'(pht_wen), 1);
        chk("init_addr", int'(pht_addr), init_k);
        chk("init_wdata", int'(pht_wdata), 1);
        chk("init_prdy", int'(pred_rdy), 0);
        chk("init_urdy", int'(upd_rdy), 0);
        init_k++;
      end else begin
        nq       = qi.size();
        exp_urdy = (nq < D);
        chk("upd_rdy", int'(upd_rdy), int'(exp_urdy));
        if (busy) begin
          chk("wr_en", int'(pht_en), 1);
          chk("wr_wen", int'(pht_wen), 1);
          chk("wr_addr", int'(pht_addr), p_idx);
          chk("wr_data", int'(pht_wdata), sat(int'(pht_rdata), p_tk));
          chk("wr_prdy", int'(pred_rdy), 0);
          busy = 0;
        end else begin
          hit = 0;
          foreach (qi[i]) if (qi[i] == int'(pred_idx)) hit = 1;
          acc = pred_val && (nq < D) && !hit;
          chk("pred_rdy", int'(pred_rdy), int'(acc));
          if (acc) begin
            chk("prd_en", int'(pht_en), 1);
            chk("prd_wen", int'(pht_wen), 0);
            chk("prd_addr", int'(pht_addr), int'(pred_idx));
            resp_pend = 1;
            resp_exp  = (gold[pred_idx] >> 1) & 1;
          end else if (nq > 0) begin
            chk("rd_en", int'(pht_en), 1);
            chk("rd_wen", int'(pht_wen), 0);
            chk("rd_addr", int'(pht_addr), qi[0]);
            p_idx = qi.pop_front();
            p_tk  = qt.pop_front();
            busy  = 1;
          end else begin
            chk("idle_en", int'(pht_en), 0);
          end
        end
        if (upd_val && exp_urdy) begin
          qi.push_back(int'(upd_idx));
          qt.push_back(int'(upd_taken));
          gold[upd_idx] = sat(gold[upd_idx], int'(upd_taken));
        end
      end
      if (pl_en) gold[pl_idx] = int'(pl_val);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic upd_test(input int pre, input int tk, input int expv);
    pl_en     = 1'b1;
    pl_idx    = 3'd3;
    pl_val    = 2'(pre);
    step();
    pl_en     = 1'b0;
    upd_val   = 1'b1;
    upd_idx   = 3'd3;
    upd_taken = 1'(tk);
    step();
    upd_val   = 1'b0;
    repeat (3) step();
    chk("lit_upd_mem3", int'(mem[3]), expv);
  endtask

  int ui [4] = '{0, 1, 2, 4};
  int ri [4] = '{0, 1, 4, 5};

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (8) step();
    foreach (mem[i]) chk("lit_init_mem", int'(mem[i]), 1);

    // First lookup right at cycle PHT_size, then back-to-back.
    pred_val = 1'b1;
    pred_idx = 3'd5;
    @(negedge clk);
    chk("lit_rdy_c8", int'(pred_rdy), 1);
    step();
    pred_idx = 3'd6;
    @(negedge clk);
    chk("lit_rval5", int'(pred_resp_val), 1);
    chk("lit_taken5", int'(pred_taken), 0);
    chk("lit_rdy6", int'(pred_rdy), 1);
    step();
    pred_val = 1'b0;
    @(negedge clk);
    chk("lit_rval6", int'(pred_resp_val), 1);
    step();

    // Saturation at both ends and a plain increment.
    upd_test(3, 1, 3);
    upd_test(0, 0, 0);
    upd_test(1, 1, 2);

    // Fill the queue under continuous lookup pressure.
    pred_val = 1'b1;
    pred_idx = 3'd7;
    for (int k = 0; k < 4; k++) begin
      upd_val   = 1'b1;
      upd_idx   = 3'(ui[k]);
      upd_taken = 1'b1;
      step();
    end
    upd_val = 1'b0;
    @(negedge clk);
    chk("lit_full_urdy", int'(upd_rdy), 0);
    chk("lit_full_prdy", int'(pred_rdy), 0);
    step();
    @(negedge clk);
    chk("lit_wr_prdy", int'(pred_rdy), 0);
    chk("lit_wr_wen", int'(pht_wen), 1);
    step();
    @(negedge clk);
    chk("lit_after_full_prdy", int'(pred_rdy), 1);
    step();
    pred_val = 1'b0;
    repeat (10) step();

    // Lookup to an index with a queued update waits for the write.
    upd_val   = 1'b1;
    upd_idx   = 3'd2;
    upd_taken = 1'b1;
    step();
    upd_val  = 1'b0;
    pred_val = 1'b1;
    pred_idx = 3'd2;
    @(negedge clk);
    chk("lit_haz_prdy", int'(pred_rdy), 0);
    chk("lit_haz_addr", int'(pht_addr), 2);
    chk("lit_haz_wen", int'(pht_wen), 0);
    step();
    @(negedge clk);
    chk("lit_haz_wr_wen", int'(pht_wen), 1);
    chk("lit_haz_wr_addr", int'(pht_addr), 2);
    chk("lit_haz_wr_prdy", int'(pred_rdy), 0);
    step();
    @(negedge clk);
    chk("lit_haz_go", int'(pred_rdy), 1);
    step();
    pred_val = 1'b0;
    @(negedge clk);
    chk("lit_haz_taken", int'(pred_taken), 1);
    chk("lit_haz_mem2", int'(mem[2]), 3);
    step();

    // Reset lands on a write-back with two entries still queued.
    for (int k = 0; k < 4; k++) begin
      upd_val   = 1'b1;
      upd_idx   = 3'(ri[k]);
      upd_taken = 1'b0;
      step();
    end
    upd_val = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    chk("lit_rst_nowr", int'(pht_wen), 0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("lit_reinit_addr", int'(pht_addr), 0);
    chk("lit_reinit_wen", int'(pht_wen), 1);
    chk("lit_reinit_urdy", int'(upd_rdy), 0);
    step();
    repeat (7) step();
    @(negedge clk);
    chk("lit_q_empty_en", int'(pht_en), 0);
    chk("lit_q_empty_urdy", int'(upd_rdy), 1);
    foreach (mem[i]) chk("lit_reinit_mem", int'(mem[i]), 1);
    step();

    pred_val = 1'b1;
    pred_idx = 3'd3;
    step();
    pred_val = 1'b0;
    repeat (3) step();
    foreach (mem[i]) chk("mem_vs_gold", int'(mem[i]), gold[i]);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
